// File: rtl/monitor_rachas_less3b_pkg.sv
// Shared types and helpers for the less-than-3 comparator run monitor.
package monitor_rachas_less3b_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALARM = 2'd2
  } state_t;

  localparam logic [2:0] LESS3_THRESH = 3'b010;

  // Reference value the comparator should produce for a given ABC.
  function automatic logic expected_f(input logic [2:0] abc);
    return (abc <= LESS3_THRESH);
  endfunction

endpackage

// File: rtl/monitor_rachas_less3b_contador_sat.sv
// Saturating up-counter with synchronous reset and a registered full flag.
module contador_sat #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         full
);

  logic [W-1:0] cnt_inc;

  assign cnt_inc = cnt + W'(1);

  // full rises on the same edge that loads the all-ones value
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      full <= 1'b0;
    end else if (en && !full) begin
      cnt  <= cnt_inc;
      full <= &cnt_inc;
    end
  end

endmodule

// File: rtl/monitor_rachas_less3b.sv
// Statistics, run-length alarm and in-circuit checker for the 3-bit less-than-3 comparator.
module monitor_rachas_less3b
  import monitor_rachas_less3b_pkg::*;
#(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [2:0]       ABC,
  input  logic             F,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [2:0]       run_cnt,
  output logic             alarm,
  output logic             mismatch,
  output logic             sat
);

  localparam logic [2:0] RUN_LEN_3 = 3'(RUN_LEN);

  state_t     state;
  logic [2:0] run_inc;
  logic       hit_full;

  assign run_inc = run_cnt + 3'd1;

  contador_sat #(.W(CNT_W)) u_total (
    .clk  (clk),
    .rst  (rst),
    .en   (valid_in),
    .cnt  (total_cnt),
    .full (sat)
  );

  contador_sat #(.W(CNT_W)) u_hit (
    .clk  (clk),
    .rst  (rst),
    .en   (valid_in && F && !hit_full),
    .cnt  (hit_cnt),
    .full (hit_full)
  );

  // Run tracking FSM; the received F drives it even when it disagrees with ABC
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      run_cnt  <= 3'd0;
      alarm    <= 1'b0;
      mismatch <= 1'b0;
    end else if (valid_in) begin
      if (F != expected_f(ABC)) begin
        mismatch <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (F) begin
            run_cnt <= 3'd1;
            if (RUN_LEN_3 == 3'd1) begin
              state <= ALARM;
              alarm <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (F) begin
            run_cnt <= run_inc;
            if (run_inc == RUN_LEN_3) begin
              state <= ALARM;
              alarm <= 1'b1;
            end
          end else begin
            run_cnt <= 3'd0;
            state   <= IDLE;
          end
        end
        ALARM: begin
          if (!F) begin
            run_cnt <= 3'd0;
            state   <= IDLE;
            alarm   <= 1'b0;
          end
        end
        default: begin
          run_cnt <= 3'd0;
          state   <= IDLE;
          alarm   <= 1'b0;
        end
      endcase
    end
  end

endmodule
